// File: rtl/psum_ofifo_pkg.sv
// Shared defaults and derived widths for the partial-sum output FIFO.
package psum_ofifo_pkg;

  localparam int DEF_COL     = 8;
  localparam int DEF_PSUM_BW = 16;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_PTR_W   = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W   = DEF_PTR_W + 1;

  // Pointer width for a power-of-two depth; the count needs one extra bit to represent "full".
  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/psum_fifo_col.sv
// One column of partial-sum storage: circular buffer, combinational head-of-queue read.
// Latency: write visible next cycle; drops writes when full, ignores pops when empty.
module psum_fifo_col
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = DEF_PSUM_BW,
  parameter int depth   = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] in,
  input  logic               rd,
  output logic [psum_bw-1:0] out,
  output logic               empty,
  output logic               full
);

  localparam int PW = ptr_w(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [psum_bw-1:0] r_mem [depth];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_cnt;
  logic               w_push;
  logic               w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == FULL_CNT);
  // A full column refuses the write even when the same edge frees a slot.
  assign w_push = wr & ~full;
  assign w_pop  = rd & ~empty;
  assign out    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in;
    end
  end

  // Depth is a power of two, so pointer overflow is the wrap from depth-1 to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/psum_ofifo.sv
// Per-column skew-absorbing output FIFO; rows pop only when every column has data, out registered (1 cycle).
// Writes to full columns are dropped, pops while not ready ignored; PSUM_OFIFO_ERR_EN adds sticky o_err.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = DEF_COL,
  parameter int psum_bw = DEF_PSUM_BW,
  parameter int depth   = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full
`ifdef PSUM_OFIFO_ERR_EN
  ,
  output logic                   o_err
`endif
);

  logic [col-1:0]         w_empty;
  logic [col-1:0]         w_full;
  logic [psum_bw*col-1:0] w_col_out;
  logic                   w_pop;
  logic [psum_bw*col-1:0] r_out;
  logic                   r_valid;

  genvar g;
  generate
    for (g = 0; g < col; g++) begin : g_col
      psum_fifo_col #(
        .psum_bw (psum_bw),
        .depth   (depth)
      ) u_col (
        .clk   (clk),
        .reset (reset),
        .wr    (wr[g]),
        .in    (in[psum_bw*g +: psum_bw]),
        .rd    (w_pop),
        .out   (w_col_out[psum_bw*g +: psum_bw]),
        .empty (w_empty[g]),
        .full  (w_full[g])
      );
    end
  endgenerate

  assign o_ready = &(~w_empty);
  assign o_full  = |w_full;
  // Rows stay aligned because all columns pop together, and only when each has an entry.
  assign w_pop   = rd & o_ready;
  assign out     = r_out;
  assign o_valid = r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_out <= w_col_out;
      end
    end
  end

`ifdef PSUM_OFIFO_ERR_EN
  logic w_drop;
  logic w_rd_ign;
  logic r_err;

  assign w_drop   = |(wr & w_full);
  assign w_rd_ign = rd & ~o_ready;
  assign o_err    = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_drop || w_rd_ign) begin
      r_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed self-checking bench for psum_ofifo (default parameters).
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [COL-1:0]      wr = '0;
  logic [BW*COL-1:0]   in = '0;
  logic                rd = 1'b0;
  logic [BW*COL-1:0]   out;
  logic                o_valid;
  logic                o_ready;
  logic                o_full;
`ifdef PSUM_OFIFO_ERR_EN
  logic                o_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in),
    .rd      (rd),
    .out     (out),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_full  (o_full)
`ifdef PSUM_OFIFO_ERR_EN
    ,
    .o_err   (o_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Row with column j = v + step*j.
  function automatic logic [BW*COL-1:0] row(input int v, input int step);
    logic [BW*COL-1:0] r;
    r = '0;
    for (int j = 0; j < COL; j++) r[j*BW +: BW] = BW'(v + step * j);
    return r;
  endfunction

  task automatic do_reset;
    wr = '0; rd = 1'b0; in = '0;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    logic [BW*COL-1:0] exp;
    #1;
    checks++; if (out !== '0) begin errors++; $display("FAIL por_out: got %h want 0", out); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL por_valid: got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL por_ready: got %b want 0", o_ready); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL por_full: got %b want 0", o_full); end
    reset = 1'b1;
    tick;
    in = row(16'h0500, 1);
    wr = '1;
    for (int k = 0; k < 6; k++) tick;
    wr = '0;
    rd = 1'b1;
    tick;
    rd = 1'b0;
    exp = row(16'h0500, 1);
    checks++; if (o_valid !== 1'b1 || out !== exp) begin errors++; $display("FAIL pre_reset_pop: got v=%b %h want v=1 %h", o_valid, out, exp); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL pre_reset_ready: got %b want 1", o_ready); end
    tick;
    #2 reset = 1'b0;
    #1;
    checks++; if (out !== '0) begin errors++; $display("FAIL mid_reset_out: got %h want 0", out); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", o_ready); end
    tick;
    reset = 1'b1;
    rd = 1'b1;
    tick;
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rd_valid: got %b want 0", o_valid); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL post_reset_ready: got %b want 0", o_ready); end
    rd = 1'b0;
  endtask

  task automatic test_skew;
    logic [BW*COL-1:0] exp;
    do_reset;
    in = row(16'h0010, 1);
    for (int i = 0; i < COL; i++) begin
      wr = '0;
      wr[i] = 1'b1;
      tick;
      wr = '0;
      checks++; if (o_ready !== (i == COL - 1)) begin errors++; $display("FAIL skew_ready[%0d]: got %b want %b", i, o_ready, (i == COL - 1)); end
    end
    rd = 1'b1;
    tick;
    rd = 1'b0;
    exp = row(16'h0010, 1);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL skew_valid: got %b want 1", o_valid); end
    checks++; if (out !== exp) begin errors++; $display("FAIL skew_out: got %h want %h", out, exp); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL skew_ready_after_pop: got %b want 0", o_ready); end
    tick;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL skew_valid_1cyc: got %b want 0", o_valid); end
    checks++; if (out !== exp) begin errors++; $display("FAIL skew_out_hold: got %h want %h", out, exp); end
  endtask

  task automatic test_full;
    do_reset;
    for (int k = 0; k < DEPTH; k++) begin
      wr = COL'(1);
      in[BW-1:0] = BW'(k);
      tick;
      if (k == DEPTH - 2) begin
        checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL full_early: got %b want 0", o_full); end
      end
    end
    wr = '0;
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", o_full); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", o_ready); end
`ifdef PSUM_OFIFO_ERR_EN
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_before_drop: got %b want 0", o_err); end
`endif
    wr = COL'(1);
    in[BW-1:0] = 16'hBEEF;
    tick;
    wr = '0;
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL full_after_drop: got %b want 1", o_full); end
`ifdef PSUM_OFIFO_ERR_EN
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_drop: got %b want 1", o_err); end
`endif
  endtask

  // Continues from test_full: column 0 already holds 0..63.
  task automatic test_full_rw;
    logic [BW*COL-1:0] exp;
    for (int k = 0; k < DEPTH; k++) begin
      wr = ~COL'(1);
      in = row(k, 256);
      tick;
    end
    wr = '0;
    checks++; if (o_ready !== 1'b1 || o_full !== 1'b1) begin errors++; $display("FAIL allfull: got ready=%b full=%b want 1 1", o_ready, o_full); end
    wr = '1;
    in = {COL{16'hAAAA}};
    rd = 1'b1;
    tick;
    wr = '0;
    exp = row(0, 256);
    checks++; if (o_valid !== 1'b1 || out !== exp) begin errors++; $display("FAIL rw_pop: got v=%b %h want v=1 %h", o_valid, out, exp); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL rw_full: got %b want 0", o_full); end
    for (int k = 1; k < DEPTH; k++) begin
      tick;
      exp = row(k, 256);
      checks++; if (o_valid !== 1'b1 || out !== exp) begin errors++; $display("FAIL drain[%0d]: got v=%b %h want v=1 %h", k, o_valid, out, exp); end
    end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", o_ready); end
    tick;
    rd = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL drain_extra_pop: got %b want 0", o_valid); end
  endtask

  task automatic test_empty_read;
    logic [BW*COL-1:0] exp;
    do_reset;
    wr = 8'hF7;
    in = row(16'h0A00, 1);
    tick;
    in = row(16'h0B00, 1);
    tick;
    wr = '0;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL er_ready: got %b want 0", o_ready); end
    rd = 1'b1;
    tick;
    rd = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL er_valid: got %b want 0", o_valid); end
`ifdef PSUM_OFIFO_ERR_EN
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL er_err: got %b want 1", o_err); end
`endif
    wr = 8'h08;
    in = row(16'h0C00, 1);
    tick;
    wr = '0;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL er_ready_after_fill: got %b want 1", o_ready); end
    rd = 1'b1;
    tick;
    rd = 1'b0;
    exp = row(16'h0A00, 1);
    exp[3*BW +: BW] = 16'h0C03;
    checks++; if (o_valid !== 1'b1 || out !== exp) begin errors++; $display("FAIL er_pop: got v=%b %h want v=1 %h", o_valid, out, exp); end
  endtask

  task automatic test_stream;
    int n;
    int pops;
    logic full_seen;
    logic [BW*COL-1:0] exp;
    do_reset;
    n = 0;
    pops = 0;
    full_seen = 1'b0;
    for (int cyc = 0; cyc < 400 && pops < 200; cyc++) begin
      wr = (n < 200) ? '1 : '0;
      in = row(n, 0);
      rd = 1'b1;
      tick;
      if (n < 200) n++;
      if (o_full === 1'b1) full_seen = 1'b1;
      if (o_valid === 1'b1) begin
        exp = row(pops, 0);
        checks++; if (out !== exp) begin errors++; $display("FAIL stream[%0d]: got %h want %h", pops, out, exp); end
        pops++;
      end
    end
    wr = '0;
    rd = 1'b0;
    checks++; if (pops != 200) begin errors++; $display("FAIL stream_count: got %0d want 200", pops); end
    checks++; if (full_seen !== 1'b0) begin errors++; $display("FAIL stream_full: got %b want 0", full_seen); end
  endtask

  initial begin
    test_reset;
    test_skew;
    test_full;
    test_full_rw;
    test_empty_read;
    test_stream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
